// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load widths, error flag positions, FSM states.
package wb_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;

  localparam int unsigned ERR_SPURIOUS = 0;
  localparam int unsigned ERR_MISALIGN = 1;
  localparam int unsigned ERR_TIMEOUT  = 2;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Picks the addressed byte/halfword of a load word and extends it; flags misaligned or illegal loads.
module load_align
  import wb_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o,
  output logic        misalign_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shifted  = rdata_i >> {addr_lo_i, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = shifted[15:0];

  always_comb begin
    data_o     = '0;
    misalign_o = 1'b0;
    case (funct3_i)
      LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LBU: data_o = {24'd0, byte_sel};
      LH: begin
        data_o     = {{16{half_sel[15]}}, half_sel};
        misalign_o = addr_lo_i[0];
      end
      LHU: begin
        data_o     = {16'd0, half_sel};
        misalign_o = addr_lo_i[0];
      end
      LW: begin
        data_o     = rdata_i;
        misalign_o = (addr_lo_i != 2'd0);
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results and loads into the register file, with a same-cycle bypass,
// load stall/timeout handling, a retired-instruction counter and sticky error flags.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_wen,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_funct3,
  input  logic [1:0]  ex_addr_lo,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  input  logic        err_clr,
  output logic        stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic [31:0] retired,
  output logic [2:0]  err
);

  localparam logic [15:0] TO_LIMIT = 16'(LOAD_TIMEOUT - 1);

  wb_state_e   state_q;
  logic [15:0] cnt_q;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;
  logic [31:0] retired_q;
  logic [2:0]  err_q, err_d, err_set;
  logic [4:0]  ld_rd_q;
  logic        ld_wen_q;
  logic [2:0]  ld_f3_q;
  logic [1:0]  ld_lo_q;
  logic        ld_poison_q;

  logic [31:0] acc_ext_unused;
  logic        acc_misalign;
  logic [31:0] ld_ext;
  logic        ld_misalign_unused;

  // Same checker twice: once on the incoming instruction, once on the returning data.
  load_align u_acc_chk (
    .funct3_i  (ex_funct3),
    .addr_lo_i (ex_addr_lo),
    .rdata_i   (32'd0),
    .data_o    (acc_ext_unused),
    .misalign_o(acc_misalign)
  );

  load_align u_ld_align (
    .funct3_i  (ld_f3_q),
    .addr_lo_i (ld_lo_q),
    .rdata_i   (dmem_rdata),
    .data_o    (ld_ext),
    .misalign_o(ld_misalign_unused)
  );

  assign stall = (state_q == WAIT_LOAD);

  always_comb begin
    err_set               = '0;
    err_set[ERR_SPURIOUS] = (state_q == IDLE) && dmem_rvalid;
    err_set[ERR_MISALIGN] = (state_q == IDLE) && ex_valid && ex_is_load && acc_misalign;
    err_set[ERR_TIMEOUT]  = (state_q == WAIT_LOAD) && !dmem_rvalid && (cnt_q == TO_LIMIT);
    err_d                 = (err_clr ? 3'b000 : err_q) | err_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      retired_q   <= '0;
      err_q       <= '0;
      ld_rd_q     <= '0;
      ld_wen_q    <= 1'b0;
      ld_f3_q     <= '0;
      ld_lo_q     <= '0;
      ld_poison_q <= 1'b0;
    end else begin
      rf_we_q <= 1'b0;
      err_q   <= err_d;
      case (state_q)
        IDLE: begin
          if (ex_valid && ex_is_load) begin
            ld_rd_q     <= ex_rd;
            ld_wen_q    <= ex_wen;
            ld_f3_q     <= ex_funct3;
            ld_lo_q     <= ex_addr_lo;
            ld_poison_q <= acc_misalign;
            cnt_q       <= '0;
            state_q     <= WAIT_LOAD;
          end else if (ex_valid) begin
            rf_we_q    <= ex_wen && (ex_rd != 5'd0);
            rf_waddr_q <= ex_rd;
            rf_wdata_q <= ex_result;
            retired_q  <= retired_q + 32'd1;
          end
        end
        WAIT_LOAD: begin
          // A response on the final allowed cycle still completes normally.
          if (dmem_rvalid) begin
            rf_we_q    <= ld_wen_q && (ld_rd_q != 5'd0) && !ld_poison_q;
            rf_waddr_q <= ld_rd_q;
            rf_wdata_q <= ld_ext;
            retired_q  <= retired_q + 32'd1;
            state_q    <= IDLE;
          end else if (cnt_q == TO_LIMIT) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign fwd_valid = rf_we_q;
  assign fwd_rd    = rf_waddr_q;
  assign fwd_data  = rf_wdata_q;
  assign retired   = retired_q;
  assign err       = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: transaction-level reference model checked every cycle, plus directed literal checks.
module tb_wb_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_wen, ex_is_load, dmem_rvalid, err_clr;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result, dmem_rdata;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic        stall, rf_we, fwd_valid;
  logic [4:0]  rf_waddr, fwd_rd;
  logic [31:0] rf_wdata, fwd_data, retired;
  logic [2:0]  err;

  int n_tests = 0;
  int n_fail  = 0;

  wb_stage #(.LOAD_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_result(ex_result),
    .ex_is_load(ex_is_load), .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .err_clr(err_clr),
    .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retired(retired), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit load_legal(input bit [2:0] f3, input bit [1:0] lo);
    int unsigned a = int'(lo);
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b1;
    if (f3 == 3'd1 || f3 == 3'd5) return (a % 2) == 0;
    if (f3 == 3'd2) return a == 0;
    return 1'b0;
  endfunction

  function automatic bit [31:0] load_value(input bit [2:0] f3, input bit [1:0] lo, input bit [31:0] w);
    int unsigned sh = 8 * int'(lo);
    bit [31:0] b = (w >> sh) & 32'hFF;
    bit [31:0] h = (w >> sh) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 128) ? b - 32'd256 : b;
      3'd1: return (h >= 32768) ? h - 32'd65536 : h;
      3'd2: return w;
      3'd4: return b;
      3'd5: return h;
      default: return 32'd0;
    endcase
  endfunction

  bit        m_busy, m_we, m_poison, m_wen, nwe;
  int        m_age;
  bit [4:0]  m_waddr, m_rd;
  bit [31:0] m_wdata, m_ret, m_word;
  bit [2:0]  m_err, m_f3, set_bits;
  bit [1:0]  m_lo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_age = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_ret = 0; m_err = 0;
    end else begin
      set_bits = 3'b000;
      nwe      = 1'b0;
      if (!m_busy) begin
        if (dmem_rvalid) set_bits[0] = 1'b1;
        if (ex_valid && ex_is_load) begin
          m_busy = 1; m_age = 0; m_rd = ex_rd; m_wen = ex_wen; m_f3 = ex_funct3; m_lo = ex_addr_lo;
          m_poison = !load_legal(ex_funct3, ex_addr_lo);
          if (m_poison) set_bits[1] = 1'b1;
        end else if (ex_valid) begin
          nwe = ex_wen && (ex_rd != 0); m_waddr = ex_rd; m_wdata = ex_result; m_ret = m_ret + 1;
        end
      end else if (dmem_rvalid) begin
        m_word = dmem_rdata;
        nwe = m_wen && (m_rd != 0) && !m_poison; m_waddr = m_rd;
        m_wdata = load_value(m_f3, m_lo, m_word); m_ret = m_ret + 1; m_busy = 0;
      end else begin
        m_age++;
        if (m_age == TO) begin m_busy = 0; set_bits[2] = 1'b1; end
      end
      m_we  = nwe;
      m_err = (err_clr ? 3'b000 : m_err) | set_bits;
    end
  end

  always @(negedge clk) begin
    check("stall", 32'(stall), 32'(m_busy));
    check("rf_we", 32'(rf_we), 32'(m_we));
    if (m_we) begin
      check("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
      check("rf_wdata", rf_wdata, m_wdata);
    end
    check("fwd_valid", 32'(fwd_valid), 32'(m_we));
    check("fwd_rd", 32'(fwd_rd), 32'(rf_waddr));
    check("fwd_data", fwd_data, rf_wdata);
    check("retired", retired, m_ret);
    check("err", 32'(err), 32'(m_err));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(input logic wen, input logic [4:0] rd, input logic [31:0] val);
    ex_valid = 1; ex_is_load = 0; ex_wen = wen; ex_rd = rd; ex_result = val;
  endtask

  // Accept a load, answer it 'dly' cycles after the accept; returns in the cycle after the response.
  task automatic load_op(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd,
                         input logic [31:0] d, input int dly);
    ex_valid = 1; ex_is_load = 1; ex_wen = 1; ex_rd = rd; ex_funct3 = f3; ex_addr_lo = lo;
    ex_result = 32'hDEAD_BEEF;
    cyc();
    ex_valid = 0; ex_is_load = 0;
    for (int i = 1; i < dly; i++) cyc();
    dmem_rvalid = 1; dmem_rdata = d;
    cyc();
    dmem_rvalid = 0; dmem_rdata = 32'h0;
  endtask

  logic [31:0] r0;
  int          nst;

  initial begin
    rst = 1; ex_valid = 0; ex_wen = 0; ex_rd = 0; ex_result = 0; ex_is_load = 0;
    ex_funct3 = 0; ex_addr_lo = 0; dmem_rvalid = 0; dmem_rdata = 0; err_clr = 0;
    cyc(); cyc();
    check("reset rf_we", 32'(rf_we), 32'd0);
    check("reset retired", retired, 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 0;
    cyc();

    // ALU x5 then x0 back to back
    alu_op(1, 5'd5, 32'h1234);
    cyc();
    check("alu x5 we", 32'(rf_we), 32'd1);
    check("alu x5 data", rf_wdata, 32'h1234);
    alu_op(1, 5'd0, 32'hFFFF);
    cyc();
    ex_valid = 0;
    check("alu x0 no write", 32'(rf_we), 32'd0);
    check("alu retired", retired, 32'd2);
    cyc();

    // LB / LBU, response 3 cycles after accept
    ex_valid = 1; ex_is_load = 1; ex_wen = 1; ex_rd = 5'd7; ex_funct3 = 3'd0; ex_addr_lo = 2'd3;
    cyc();
    ex_valid = 0; ex_is_load = 0;
    nst = 0;
    for (int i = 0; i < 3; i++) begin
      if (stall) nst++;
      if (i == 2) begin dmem_rvalid = 1; dmem_rdata = 32'h80AABBCC; end
      cyc();
    end
    dmem_rvalid = 0;
    check("lb stall cycles", 32'(nst), 32'd3);
    check("lb data", rf_wdata, 32'hFFFFFF80);
    check("lb stall released", 32'(stall), 32'd0);
    load_op(3'd4, 2'd3, 5'd8, 32'h80AABBCC, 3);
    check("lbu data", rf_wdata, 32'h00000080);
    load_op(3'd1, 2'd2, 5'd9, 32'h8001_0000, 1);
    check("lh data", rf_wdata, 32'hFFFF8001);
    load_op(3'd5, 2'd0, 5'd10, 32'h1234_9ABC, 2);
    check("lhu data", rf_wdata, 32'h00009ABC);
    load_op(3'd2, 2'd0, 5'd11, 32'hCAFE_F00D, TO);
    check("lw at limit data", rf_wdata, 32'hCAFEF00D);
    check("lw at limit no timeout", 32'(err), 32'd0);
    cyc();

    // misaligned LH
    r0 = retired;
    load_op(3'd1, 2'd1, 5'd12, 32'h5555_AAAA, 2);
    check("misalign err", 32'(err), 32'b010);
    check("misalign no write", 32'(rf_we), 32'd0);
    check("misalign retired", retired, r0 + 1);
    err_clr = 1;
    cyc();
    err_clr = 0;
    check("err_clr", 32'(err), 32'd0);

    // timeout
    r0 = retired;
    ex_valid = 1; ex_is_load = 1; ex_wen = 1; ex_rd = 5'd13; ex_funct3 = 3'd2; ex_addr_lo = 2'd0;
    cyc();
    ex_valid = 0; ex_is_load = 0;
    nst = 0;
    for (int i = 0; i < 20 && stall; i++) begin nst++; cyc(); end
    check("timeout stall cycles", 32'(nst), 32'(TO));
    check("timeout err", 32'(err), 32'b100);
    check("timeout no write", 32'(rf_we), 32'd0);
    check("timeout retired", retired, r0);
    dmem_rvalid = 1;
    cyc();
    dmem_rvalid = 0;
    check("spurious err", 32'(err), 32'b101);
    err_clr = 1; dmem_rvalid = 1;
    cyc();
    dmem_rvalid = 0;
    check("set beats clear", 32'(err), 32'b001);
    cyc();
    err_clr = 0;
    check("clear all", 32'(err), 32'd0);

    // reset in the middle of a load
    ex_valid = 1; ex_is_load = 1; ex_wen = 1; ex_rd = 5'd14; ex_funct3 = 3'd0; ex_addr_lo = 2'd1;
    cyc();
    ex_valid = 0; ex_is_load = 0;
    cyc();
    rst = 1;
    #1;
    check("rst stall", 32'(stall), 32'd0);
    check("rst rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst rf_wdata", rf_wdata, 32'd0);
    check("rst retired", retired, 32'd0);
    cyc();
    rst = 0;
    dmem_rvalid = 1; dmem_rdata = 32'h0000_FF00;
    cyc();
    dmem_rvalid = 0;
    check("post-rst spurious", 32'(err), 32'b001);
    alu_op(1, 5'd3, 32'h0000CAFE);
    cyc();
    ex_valid = 0;
    check("post-rst alu data", rf_wdata, 32'h0000CAFE);
    check("post-rst retired", retired, 32'd1);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failures=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
